simd_align_shifter_pipe: RTL and testbench

- Pipelined, flow-controlled successor of the FP-adder alignment barrel shifter.
- Right-shifts one FP32 significand, or two packed FP16-lane significands, and produces a per-lane sticky bit.
- The shift amount is a full 8-bit exponent difference with saturation, so out-of-range shifts are handled correctly.
- Sits between exponent-difference logic and the significand adder; a valid/ready handshake allows back-pressure from the adder/normaliser.

---
 rtl/simd_align_shifter_pipe_if.sv | 66 ++++++
 rtl/simd_align_shifter_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_simd_align_shifter_pipe.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simd_align_shifter_pipe_if.sv
// -----------------------------------------------------------------------------
// simd_align_pkg / simd_align_shifter_pipe_if
//
// Purpose:
//   The package holds the floating-point format enumeration shared by the
//   shifter and its users. The interface bundles the input and output
//   valid/ready channels of simd_align_shifter_pipe.
//
// Port summary (interface signals):
//   in_valid / in_ready        input beat handshake
//   in_fmt, in_x, in_s, in_tag input beat payload (format, significand,
//                              shift amount, sideband tag)
//   out_valid / out_ready      result beat handshake
//   out_fmt, out_r, out_tag    result beat payload
//   out_sticky_h, out_sticky_l per-lane sticky bits
//
// Modports:
//   master - producer of input beats and consumer of results
//   slave  - the shifter itself
// -----------------------------------------------------------------------------
package simd_align_pkg;

    typedef enum logic [1:0] {
        FP32 = 2'd0,
        FP16 = 2'd1,
        BF16 = 2'd2,
        FP8  = 2'd3
    } fp_fmt_e;

endpackage

interface simd_align_shifter_pipe_if #(
    parameter int FRAC32 = 24,
    parameter int GRD32  = 2,
    parameter int TAG_W  = 4
) ();
    import simd_align_pkg::*;

    localparam int W32 = FRAC32 + GRD32;

    logic              in_valid;
    logic              in_ready;
    fp_fmt_e           in_fmt;
    logic [FRAC32-1:0] in_x;
    logic [7:0]        in_s;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    fp_fmt_e           out_fmt;
    logic [W32-1:0]    out_r;
    logic              out_sticky_h;
    logic              out_sticky_l;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_fmt, in_x, in_s, in_tag, out_ready,
        input  in_ready, out_valid, out_fmt, out_r, out_sticky_h, out_sticky_l, out_tag
    );

    modport slave (
        input  in_valid, in_fmt, in_x, in_s, in_tag, out_ready,
        output in_ready, out_valid, out_fmt, out_r, out_sticky_h, out_sticky_l, out_tag
    );

endinterface

// File: rtl/simd_align_shifter_pipe.sv
// -----------------------------------------------------------------------------
// simd_align_shifter_pipe
//
// Purpose:
//   Alignment right-shifter for an FP adder. Shifts either one FP32
//   significand (with guard bits) or two packed FP16-lane significands by an
//   exponent difference, producing a sticky bit per lane. The five shift
//   levels (16, 8, 4, 2, 1) may each be followed by an optional pipeline
//   register; the output register is always present. A global advance enable
//   provides valid/ready flow control with full throughput.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, discards all in-flight beats
//   bus  - simd_align_shifter_pipe_if.slave (input and output channels)
// -----------------------------------------------------------------------------
module simd_align_shifter_pipe
    import simd_align_pkg::*;
#(
    parameter int         FRAC32    = 24,
    parameter int         GRD32     = 2,
    parameter int         FRAC16    = 8,
    parameter int         PAD16     = 5,
    parameter logic [4:0] REG_AFTER = 5'b00000,
    parameter int         TAG_W     = 4
) (
    input logic                      clk,
    input logic                      rst,
    simd_align_shifter_pipe_if.slave bus
);

    localparam int         W32   = FRAC32 + GRD32;
    localparam int         W16   = FRAC16 + PAD16;
    localparam logic [7:0] W32_S = 8'(W32);
    localparam logic [3:0] W16_S = 4'(W16);

    if (W32 != 2 * W16) begin : g_bad_geometry
        $error("simd_align_shifter_pipe: W32 must equal 2*W16");
    end

    // One beat as it moves through the shift levels. sel_l drives the FP32
    // shift (and the low FP16 lane); sel_h drives the high FP16 lane. zero_*
    // remember that the amount saturated so the result is masked at the end.
    typedef struct packed {
        logic             valid;
        fp_fmt_e          fmt;
        logic [TAG_W-1:0] tag;
        logic [W32-1:0]   data;
        logic             sticky_h;
        logic             sticky_l;
        logic [4:0]       sel_h;
        logic [4:0]       sel_l;
        logic             zero_h;
        logic             zero_l;
    } stage_t;

    typedef struct packed {
        logic             valid;
        fp_fmt_e          fmt;
        logic [TAG_W-1:0] tag;
        logic [W32-1:0]   data;
        logic             sticky_h;
        logic             sticky_l;
    } out_t;

    logic   en;
    stage_t head;
    stage_t tail;
    out_t   out_q;
    out_t   out_nxt;
    logic   sat_h;
    logic   sat_l;
    logic   sat32;

    // A stall at the output freezes every stage; bubbles are not squeezed.
    assign en           = !out_q.valid || bus.out_ready;
    assign bus.in_ready = en;

    // Operand formation and saturation of the shift amount. Saturated amounts
    // force every level select so all bits fall into the sticky.
    always_comb begin
        head       = '0;
        sat_h      = 1'b0;
        sat_l      = 1'b0;
        sat32      = 1'b0;
        head.valid = bus.in_valid;
        head.fmt   = bus.in_fmt;
        head.tag   = bus.in_tag;
        if (bus.in_fmt == FP16) begin
            sat_h       = (bus.in_s[7:4] >= W16_S);
            sat_l       = (bus.in_s[3:0] >= W16_S);
            head.data   = {bus.in_x[FRAC32-1 -: FRAC16], {PAD16{1'b0}},
                           bus.in_x[FRAC32/2-1 -: FRAC16], {PAD16{1'b0}}};
            head.sel_h  = sat_h ? 5'b01111 : {1'b0, bus.in_s[7:4]};
            head.sel_l  = sat_l ? 5'b01111 : {1'b0, bus.in_s[3:0]};
            head.zero_h = sat_h;
            head.zero_l = sat_l;
        end else begin
            sat32       = (bus.in_s >= W32_S);
            head.data   = {bus.in_x, {GRD32{1'b0}}};
            head.sel_h  = 5'b00000;
            head.sel_l  = sat32 ? 5'b11111 : bus.in_s[4:0];
            head.zero_h = 1'b0;
            head.zero_l = sat32;
        end
    end

    for (genvar j = 0; j < 5; j++) begin : g_lvl
        localparam int K  = 4 - j;
        localparam int SH = 1 << K;
        localparam logic [W32-1:0] M32 = W32'((64'd1 << SH) - 64'd1);
        localparam logic [W16-1:0] M16 = W16'((64'd1 << SH) - 64'd1);

        stage_t         d_in;
        stage_t         d_out;
        stage_t         nxt;
        logic [W16-1:0] hi;
        logic [W16-1:0] lo;

        if (j == 0) begin : g_first
            assign d_in = head;
        end else begin : g_chain
            assign d_in = g_lvl[j-1].d_out;
        end

        // Shift by 2^K; in FP16 mode each lane shifts on its own select so
        // nothing crosses the lane boundary. Shifted-out bits feed the sticky.
        always_comb begin
            nxt = d_in;
            hi  = d_in.data[W32-1:W16];
            lo  = d_in.data[W16-1:0];
            if (d_in.fmt == FP16) begin
                if (d_in.sel_h[K]) begin
                    nxt.sticky_h = d_in.sticky_h | (|(hi & M16));
                    hi           = hi >> SH;
                end else begin
                    nxt.sticky_h = d_in.sticky_h;
                end
                if (d_in.sel_l[K]) begin
                    nxt.sticky_l = d_in.sticky_l | (|(lo & M16));
                    lo           = lo >> SH;
                end else begin
                    nxt.sticky_l = d_in.sticky_l;
                end
                nxt.data = {hi, lo};
            end else begin
                if (d_in.sel_l[K]) begin
                    nxt.sticky_l = d_in.sticky_l | (|(d_in.data & M32));
                    nxt.data     = d_in.data >> SH;
                end else begin
                    nxt.data     = d_in.data;
                end
            end
        end

        if (REG_AFTER[K]) begin : g_reg
            stage_t q;

            // Optional pipeline register after this level.
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else if (en) begin
                    q <= nxt;
                end else begin
                    q <= q;
                end
            end

            assign d_out = q;
        end else begin : g_comb
            assign d_out = nxt;
        end
    end

    assign tail = g_lvl[4].d_out;

    logic unused_sel;
    assign unused_sel = ^{tail.sel_h, tail.sel_l};

    // Result masking for saturated amounts; payload only updates on a valid beat.
    always_comb begin
        out_nxt       = out_q;
        out_nxt.valid = tail.valid;
        if (tail.valid) begin
            out_nxt.fmt      = tail.fmt;
            out_nxt.tag      = tail.tag;
            out_nxt.sticky_h = tail.sticky_h;
            out_nxt.sticky_l = tail.sticky_l;
            if (tail.fmt == FP16) begin
                out_nxt.data = {tail.zero_h ? {W16{1'b0}} : tail.data[W32-1:W16],
                                tail.zero_l ? {W16{1'b0}} : tail.data[W16-1:0]};
            end else begin
                out_nxt.data = tail.zero_l ? {W32{1'b0}} : tail.data;
            end
        end else begin
            out_nxt.data = out_q.data;
        end
    end

    // Output register, always present; holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else if (en) begin
            out_q <= out_nxt;
        end else begin
            out_q <= out_q;
        end
    end

    assign bus.out_valid    = out_q.valid;
    assign bus.out_fmt      = out_q.fmt;
    assign bus.out_tag      = out_q.tag;
    assign bus.out_r        = out_q.data;
    assign bus.out_sticky_h = out_q.sticky_h;
    assign bus.out_sticky_l = out_q.sticky_l;

endmodule

// File: tb/tb_simd_align_shifter_pipe.sv
// -----------------------------------------------------------------------------
// tb_simd_align_shifter_pipe
//
// Drives two shifter instances from the same stimulus: dut0 with no internal
// pipeline registers (latency 1) and dut1 with registers after the 8 and 2
// levels (latency 3). A scoreboard per instance holds expected beats computed
// by an arithmetic model of the shift/sticky rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_simd_align_shifter_pipe;
    import simd_align_pkg::*;

    typedef struct packed {
        fp_fmt_e     fmt;
        logic [3:0]  tag;
        logic [25:0] r;
        logic        sh;
        logic        sl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    fp_fmt_e     in_fmt;
    logic [23:0] in_x;
    logic [7:0]  in_s;
    logic [3:0]  in_tag;

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic prev_stall [2];
    exp_t prev_got [2];
    logic last_acc [2];
    int   acc1  = 0;
    int   pops1 = 0;

    always #5 clk = ~clk;

    simd_align_shifter_pipe_if #(.FRAC32(24), .GRD32(2), .TAG_W(4)) bus0 ();
    simd_align_shifter_pipe_if #(.FRAC32(24), .GRD32(2), .TAG_W(4)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_fmt    = in_fmt;
    assign bus0.in_x      = in_x;
    assign bus0.in_s      = in_s;
    assign bus0.in_tag    = in_tag;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_fmt    = in_fmt;
    assign bus1.in_x      = in_x;
    assign bus1.in_s      = in_s;
    assign bus1.in_tag    = in_tag;
    assign bus1.out_ready = out_ready;

    simd_align_shifter_pipe #(.FRAC32(24), .GRD32(2), .FRAC16(8), .PAD16(5),
                              .REG_AFTER(5'b00000), .TAG_W(4)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    simd_align_shifter_pipe #(.FRAC32(24), .GRD32(2), .FRAC16(8), .PAD16(5),
                              .REG_AFTER(5'b01010), .TAG_W(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Reference: plain integer arithmetic on the shift rules.
    function automatic exp_t model(fp_fmt_e f, logic [3:0] t, logic [23:0] x, logic [7:0] s);
        exp_t            e;
        longint unsigned v, r, hv, lv, hr, lr;
        int              sa, sb;
        e.fmt = f;
        e.tag = t;
        e.sh  = 1'b0;
        e.sl  = 1'b0;
        if (f == FP16) begin
            hv = 64'(x[23:16]) * 64'd32;
            lv = 64'(x[11:4]) * 64'd32;
            sa = int'(s[7:4]);
            sb = int'(s[3:0]);
            if (sa >= 13) begin
                hr   = 64'd0;
                e.sh = (hv != 64'd0);
            end else begin
                hr   = hv >> sa;
                e.sh = ((hv % (64'd1 << sa)) != 64'd0);
            end
            if (sb >= 13) begin
                lr   = 64'd0;
                e.sl = (lv != 64'd0);
            end else begin
                lr   = lv >> sb;
                e.sl = ((lv % (64'd1 << sb)) != 64'd0);
            end
            e.r = 26'(hr * 64'd8192 + lr);
        end else begin
            v = 64'(x) * 64'd4;
            if (int'(s) >= 26) begin
                r    = 64'd0;
                e.sl = (v != 64'd0);
            end else begin
                r    = v >> int'(s);
                e.sl = ((v % (64'd1 << int'(s))) != 64'd0);
            end
            e.r = 26'(r);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, check against scoreboards, then
    // return 1 time unit after the rising edge.
    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            logic ov;
            logic ir;
            logic has;
            exp_t got;
            exp_t want;
            if (d == 0) begin
                ov = bus0.out_valid; ir = bus0.in_ready;
                got = '{bus0.out_fmt, bus0.out_tag, bus0.out_r, bus0.out_sticky_h, bus0.out_sticky_l};
                has = (q0.size() > 0);
                want = has ? q0[0] : '0;
            end else begin
                ov = bus1.out_valid; ir = bus1.in_ready;
                got = '{bus1.out_fmt, bus1.out_tag, bus1.out_r, bus1.out_sticky_h, bus1.out_sticky_l};
                has = (q1.size() > 0);
                want = has ? q1[0] : '0;
            end
            chk(d == 0 ? "in_ready0" : "in_ready1", 64'(ir), 64'(out_ready || !ov));
            if (ov) begin
                chk(d == 0 ? "sb_nonempty0" : "sb_nonempty1", 64'(has), 64'd1);
                if (has) chk(d == 0 ? "out_beat0" : "out_beat1", 64'(got), 64'(want));
            end
            if (prev_stall[d]) chk(d == 0 ? "stall_hold0" : "stall_hold1",
                                   {29'd0, ov, got}, {29'd0, 1'b1, prev_got[d]});
            last_acc[d] = 1'b0;
            if (rst) begin
                if (d == 0) q0.delete(); else q1.delete();
                prev_stall[d] = 1'b0;
            end else begin
                if (ov && out_ready && has) begin
                    if (d == 0) void'(q0.pop_front());
                    else begin void'(q1.pop_front()); pops1++; end
                end
                if (in_valid && ir) begin
                    last_acc[d] = 1'b1;
                    if (d == 0) q0.push_back(model(in_fmt, in_tag, in_x, in_s));
                    else begin q1.push_back(model(in_fmt, in_tag, in_x, in_s)); acc1++; end
                end
                prev_stall[d] = ov && !out_ready;
                prev_got[d]   = got;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Single beat into both instances, then check dut0 (latency 1) directly.
    task automatic beat32(input fp_fmt_e f, input logic [23:0] x, input logic [7:0] s,
                          input logic [25:0] er, input logic esh, input logic esl);
        in_valid = 1'b1; in_fmt = f; in_x = x; in_s = s; in_tag = in_tag + 4'd1;
        step();
        in_valid = 1'b0;
        chk("dir_valid", 64'(bus0.out_valid), 64'd1);
        chk("dir_r", 64'(bus0.out_r), 64'(er));
        chk("dir_sticky_h", 64'(bus0.out_sticky_h), 64'(esh));
        chk("dir_sticky_l", 64'(bus0.out_sticky_l), 64'(esl));
    endtask

    initial begin
        int         n;
        int         tag_i;
        int         cyc;
        int         p0;
        logic [7:0] corner [7];
        corner = '{8'd0, 8'd12, 8'd13, 8'd15, 8'd25, 8'd26, 8'd255};
        prev_stall = '{1'b0, 1'b0};
        last_acc   = '{1'b0, 1'b0};
        prev_got   = '{'0, '0};
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_fmt = FP32; in_x = 24'd0; in_s = 8'd0; in_tag = 4'd0;

        // Reset state
        step();
        step();
        rst = 1'b0;
        chk("rst_valid0", 64'(bus0.out_valid), 64'd0);
        chk("rst_valid1", 64'(bus1.out_valid), 64'd0);
        chk("rst_r1", 64'(bus1.out_r), 64'd0);
        chk("rst_tag1", 64'(bus1.out_tag), 64'd0);
        chk("rst_fmt1", 64'(bus1.out_fmt), 64'(FP32));
        chk("rst_sticky1", {62'd0, bus1.out_sticky_h, bus1.out_sticky_l}, 64'd0);
        chk("rst_in_ready1", 64'(bus1.in_ready), 64'd1);

        // Directed FP32 / saturation / FP16 cases
        beat32(FP32, 24'hC00001, 8'd2,   26'h0C00001, 1'b0, 1'b0);
        beat32(FP32, 24'hC00001, 8'd3,   26'h0600000, 1'b0, 1'b1);
        beat32(FP32, 24'h800000, 8'd26,  26'h0000000, 1'b0, 1'b1);
        beat32(FP32, 24'h800000, 8'd200, 26'h0000000, 1'b0, 1'b1);
        beat32(FP32, 24'h000000, 8'd200, 26'h0000000, 1'b0, 1'b0);
        beat32(FP16, 24'hFF0A50, 8'h3D,  26'h07F8000, 1'b0, 1'b1);
        beat32(FP16, 24'hFF0A50, 8'h00,  {13'h1FE0, 13'h14A0}, 1'b0, 1'b0);
        beat32(BF16, 24'hFFFFFF, 8'd25,  26'h0000001, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step();

        // Throughput under back-pressure: 8 tagged beats, ready pattern 1,0,0
        tag_i = 0; cyc = 0; p0 = pops1;
        while (!(tag_i == 8 && pops1 - p0 == 8) && cyc < 200) begin
            in_valid  = (tag_i < 8);
            in_tag    = 4'(tag_i);
            in_fmt    = fp_fmt_e'(2'($urandom));
            in_x      = 24'($urandom);
            in_s      = 8'($urandom);
            out_ready = (cyc % 3 == 0);
            step();
            if (last_acc[1]) tag_i++;
            cyc++;
        end
        chk("thru_beats", 64'(pops1 - p0), 64'd8);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Reset with three beats in flight
        in_valid = 1'b1; in_fmt = FP32; in_x = 24'hABCDEF; in_s = 8'd1; in_tag = 4'd9;
        step(); step(); step();
        chk("inflight_valid", 64'(bus1.out_valid), 64'd1);
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", 64'(bus1.out_valid), 64'd0);
        chk("midrst_r", 64'(bus1.out_r), 64'd0);
        chk("midrst_tag", 64'(bus1.out_tag), 64'd0);
        chk("midrst_in_ready", 64'(bus1.in_ready), 64'd1);
        in_valid = 1'b1; in_x = 24'h123456; in_s = 8'd4; in_tag = 4'd5;
        step();
        in_valid = 1'b0;
        n = 1;
        while (!bus1.out_valid && n < 10) begin
            step();
            n++;
        end
        chk("post_rst_latency", 64'(n), 64'd3);
        for (int i = 0; i < 3; i++) step();

        // Randomised mixed-format traffic
        acc1 = 0; cyc = 0;
        while (acc1 < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(4) != 0);
            out_ready = ($urandom_range(3) != 0);
            in_fmt    = fp_fmt_e'(2'($urandom));
            in_x      = 24'($urandom);
            in_tag    = 4'($urandom);
            in_s      = ($urandom_range(9) < 3) ? corner[$urandom_range(6)] : 8'($urandom);
            step();
            cyc++;
        end
        chk("random_beats", 64'(acc1 >= 10000), 64'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("drained0", 64'(q0.size()), 64'd0);
        chk("drained1", 64'(q1.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
